// File: rtl/wireless_requester.sv
// Requesting end of the single-byte request/response link: polls telemetry
// bytes into shadow registers and commits them as one frame, or writes a setting.
module wireless_requester #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        poll_req,
    input  logic        cfg_heart_req,
    input  logic [7:0]  cfg_heart_val,
    input  logic        cfg_wheel_req,
    input  logic [7:0]  cfg_wheel_val,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        is_transmitting,
    output logic [7:0]  heart_rate,
    output logic [9:0]  resolved_angle,
    output logic [7:0]  speed,
    output logic [11:0] adc,
    output logic        frame_valid,
    output logic        cfg_done,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_nack
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, COMMIT, ABORT} state_t;
    typedef enum logic [1:0] {OP_POLL, OP_HEART, OP_WHEEL} op_t;

    state_t        state, next_state;
    op_t           op;
    logic [2:0]    step;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] timer;
    logic [7:0]    cfg_val;
    logic [7:0]    load_byte;
    logic          pend_poll, pend_heart, pend_wheel;
    logic          last_nack;
    logic [7:0]    sh_hr, sh_speed, sh_adc_lo;
    logic [9:0]    sh_angle;

    logic want_heart, want_wheel, want_poll;
    logic take_heart, take_wheel, take_poll, accept;
    logic is_cfg, in_wait, got_nack, got_timeout, fail, step_ok, last_step, exhausted;

    assign want_heart  = pend_heart | cfg_heart_req;
    assign want_wheel  = pend_wheel | cfg_wheel_req;
    assign want_poll   = pend_poll  | poll_req;
    assign take_heart  = (state == IDLE) && want_heart;
    assign take_wheel  = (state == IDLE) && !want_heart && want_wheel;
    assign take_poll   = (state == IDLE) && !want_heart && !want_wheel && want_poll;
    assign accept      = take_heart | take_wheel | take_poll;

    // A received pulse beats a timeout expiring on the same cycle.
    assign is_cfg      = (op != OP_POLL);
    assign in_wait     = (state == WAIT);
    assign got_nack    = in_wait && received && is_cfg && (rx_byte != 8'd1);
    assign got_timeout = in_wait && !received && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign fail        = got_nack | got_timeout;
    assign step_ok     = in_wait && received && !got_nack;
    assign last_step   = is_cfg ? (step == 3'd1) : (step == 3'd5);
    assign exhausted   = (retry_cnt == RW'(MAX_RETRY));

    always_comb begin
        load_byte = 8'd0;
        case (op)
            OP_POLL: begin
                case (step)
                    3'd0:    load_byte = 8'd1;
                    3'd1:    load_byte = 8'd2;
                    3'd2:    load_byte = 8'd3;
                    3'd3:    load_byte = 8'd4;
                    3'd4:    load_byte = 8'd7;
                    default: load_byte = 8'd8;
                endcase
            end
            OP_HEART: load_byte = (step == 3'd0) ? 8'd5 : cfg_val;
            default:  load_byte = (step == 3'd0) ? 8'd6 : cfg_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept) next_state = LOAD;
            LOAD:   next_state = SEND;
            SEND:   if (!is_transmitting) next_state = WAIT;
            WAIT: begin
                if (step_ok)   next_state = last_step ? COMMIT : LOAD;
                else if (fail) next_state = exhausted ? ABORT : SEND;
            end
            COMMIT: next_state = IDLE;
            ABORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        transmit    = (state == SEND) && !is_transmitting;
        busy        = (state != IDLE);
        frame_valid = (state == COMMIT) && (op == OP_POLL);
        cfg_done    = (state == COMMIT) && (op != OP_POLL);
    end

    // The final poll response goes straight into the outputs together with the
    // shadows, so the frame appears whole on the COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= OP_POLL; step <= 3'd0; retry_cnt <= '0; timer <= '0;
            cfg_val <= 8'd0; tx_byte <= 8'd0; last_nack <= 1'b0;
            pend_poll <= 1'b0; pend_heart <= 1'b0; pend_wheel <= 1'b0;
            err_timeout <= 1'b0; err_nack <= 1'b0;
            sh_hr <= 8'd0; sh_angle <= 10'd0; sh_speed <= 8'd0; sh_adc_lo <= 8'd0;
            heart_rate <= 8'd0; resolved_angle <= 10'd0; speed <= 8'd0; adc <= 12'd0;
        end else begin
            pend_heart <= want_heart & ~take_heart;
            pend_wheel <= want_wheel & ~take_wheel;
            pend_poll  <= want_poll  & ~take_poll;
            timer      <= in_wait ? timer + TW'(1) : '0;
            if (accept) begin
                op          <= take_heart ? OP_HEART : (take_wheel ? OP_WHEEL : OP_POLL);
                cfg_val     <= take_heart ? cfg_heart_val : cfg_wheel_val;
                step        <= 3'd0;
                retry_cnt   <= '0;
                err_timeout <= 1'b0;
                err_nack    <= 1'b0;
            end
            if (state == LOAD) tx_byte <= load_byte;
            if (fail) begin
                last_nack <= got_nack;
                if (!exhausted) retry_cnt <= retry_cnt + RW'(1);
            end
            if (step_ok) begin
                step      <= step + 3'd1;
                retry_cnt <= '0;
                if (op == OP_POLL) begin
                    case (step)
                        3'd0: sh_hr          <= rx_byte;
                        3'd1: sh_angle[9:8]  <= rx_byte[1:0];
                        3'd2: sh_angle[7:0]  <= rx_byte;
                        3'd3: sh_speed       <= rx_byte;
                        3'd4: sh_adc_lo      <= rx_byte;
                        default: begin
                            heart_rate     <= sh_hr;
                            resolved_angle <= sh_angle;
                            speed          <= sh_speed;
                            adc            <= {rx_byte[3:0], sh_adc_lo};
                        end
                    endcase
                end
            end
            if (state == ABORT) begin
                err_timeout <= !last_nack;
                err_nack    <= last_nack;
                sh_hr <= 8'd0; sh_angle <= 10'd0; sh_speed <= 8'd0; sh_adc_lo <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_wireless_requester.sv
// Bench for wireless_requester: a behavioural responder answers each request byte
// from its own telemetry, and a scoreboard monitor checks bytes, frames and acks.
module tb_wireless_requester;
    localparam int TO = 100;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        poll_req = 1'b0, cfg_heart_req = 1'b0, cfg_wheel_req = 1'b0;
    logic [7:0]  cfg_heart_val = 8'd0, cfg_wheel_val = 8'd0;
    logic        transmit, received, is_transmitting = 1'b0;
    logic [7:0]  tx_byte, rx_byte;
    logic [7:0]  heart_rate, speed;
    logic [9:0]  resolved_angle;
    logic [11:0] adc;
    logic        frame_valid, cfg_done, busy, err_timeout, err_nack;

    wireless_requester #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n),
        .poll_req(poll_req), .cfg_heart_req(cfg_heart_req), .cfg_heart_val(cfg_heart_val),
        .cfg_wheel_req(cfg_wheel_req), .cfg_wheel_val(cfg_wheel_val),
        .transmit(transmit), .tx_byte(tx_byte), .received(received), .rx_byte(rx_byte),
        .is_transmitting(is_transmitting),
        .heart_rate(heart_rate), .resolved_angle(resolved_angle), .speed(speed), .adc(adc),
        .frame_valid(frame_valid), .cfg_done(cfg_done), .busy(busy),
        .err_timeout(err_timeout), .err_nack(err_nack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int req_cyc = 0;

    // Responder telemetry and behaviour knobs
    logic [7:0]  r_hr, r_spd;
    logic [9:0]  r_ang;
    logic [11:0] r_adc;
    int silent_code = -1;
    int nack_plan = 0;
    int stray_count = 0;

    // Scoreboard
    int          exp_tx[$];
    logic [37:0] exp_frames[$];
    int          exp_cfg[$];
    int          tx_log_cyc[$];
    int          tx_log_byte[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic failNow(input string name, input int act);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=%0d required=none", name, act);
    endtask

    task automatic applyStimulus(input bit p, input bit h, input logic [7:0] hv,
                                 input bit w, input logic [7:0] wv);
        @(posedge clk); #1;
        poll_req = p; cfg_heart_req = h; cfg_heart_val = hv;
        cfg_wheel_req = w; cfg_wheel_val = wv;
        req_cyc = cyc;
        @(posedge clk); #1;
        poll_req = 1'b0; cfg_heart_req = 1'b0; cfg_wheel_req = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(posedge clk); #1;
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        if (n >= budget) failNow("idle_timeout", n);
    endtask

    task automatic pushPoll();
        exp_tx.push_back(1); exp_tx.push_back(2); exp_tx.push_back(3);
        exp_tx.push_back(4); exp_tx.push_back(7); exp_tx.push_back(8);
        exp_frames.push_back({r_hr, r_ang, r_spd, r_adc});
    endtask

    task automatic pushCfg(input int code, input logic [7:0] val, input int nacks);
        for (int i = 0; i <= nacks; i++) exp_tx.push_back(code);
        exp_tx.push_back(int'(val));
        exp_cfg.push_back(code);
        nack_plan += nacks;
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Far-end responder: answers each request byte from its own telemetry.
    initial begin : responder
        bit expect_value = 1'b0;
        int stray_done = 0;
        int nacks_given = 0;
        logic [7:0] code, resp;
        received = 1'b0;
        rx_byte = 8'd0;
        forever begin
            @(negedge clk);
            if (stray_count != stray_done) begin
                stray_done = stray_count;
                @(posedge clk); #1 received = 1'b1; rx_byte = 8'hA5;
                @(posedge clk); #1 received = 1'b0;
            end else if (rst_n && transmit) begin
                code = tx_byte;
                resp = 8'd0;
                if (expect_value) begin
                    resp = 8'd1;
                    expect_value = 1'b0;
                end else begin
                    case (code)
                        8'd1: resp = r_hr;
                        8'd2: resp = {6'($urandom), r_ang[9:8]};
                        8'd3: resp = r_ang[7:0];
                        8'd4: resp = r_spd;
                        8'd7: resp = r_adc[7:0];
                        8'd8: resp = {4'($urandom), r_adc[11:8]};
                        8'd5, 8'd6: begin
                            if (nacks_given < nack_plan) begin
                                nacks_given++;
                                resp = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(2, 255));
                            end else begin
                                resp = 8'd1;
                                expect_value = 1'b1;
                            end
                        end
                        default: resp = 8'hEE;
                    endcase
                end
                if (int'(code) != silent_code) begin
                    repeat ($urandom_range(0, 7)) @(posedge clk);
                    @(posedge clk); #1 received = 1'b1; rx_byte = resp;
                    @(posedge clk); #1 received = 1'b0; rx_byte = 8'($urandom);
                end
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin : monitor
        logic [37:0] cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) cur = '0;
            if (transmit) begin
                tx_log_cyc.push_back(cyc);
                tx_log_byte.push_back(int'(tx_byte));
                checkOutput("tx_uart_idle", 64'(is_transmitting), 64'(0));
                if (exp_tx.size() == 0) failNow("tx_unexpected", int'(tx_byte));
                else checkOutput("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
            end
            if (frame_valid) begin
                if (exp_frames.size() == 0) failNow("frame_unexpected", 1);
                else cur = exp_frames.pop_front();
            end
            checkOutput("frame_out", 64'({heart_rate, resolved_angle, speed, adc}), 64'(cur));
            if (cfg_done) begin
                if (exp_cfg.size() == 0) failNow("cfg_done_unexpected", 1);
                else begin
                    void'(exp_cfg.pop_front());
                    checkOutput("cfg_err_flags", 64'({err_timeout, err_nack}), 64'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=%0d required=finish", cyc);
        $fatal(1, "[TB] simulation hung");
    end

    initial begin : stimulus
        int idx0;
        int gap;
        int n;
        int kind;
        int nk;
        logic [7:0] v;

        // Reset values
        repeat (3) @(posedge clk); #1;
        checkOutput("reset_outputs",
                    64'({heart_rate, resolved_angle, speed, adc}), 64'(0));
        checkOutput("reset_flags",
                    64'({transmit, frame_valid, cfg_done, busy, err_timeout, err_nack, tx_byte}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed poll
        r_hr = 8'd72; r_ang = 10'h25A; r_spd = 8'd30; r_adc = 12'hC34;
        idx0 = tx_log_cyc.size();
        pushPoll();
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        waitIdle(400);
        checkOutput("poll_tx_count", 64'(tx_log_cyc.size() - idx0), 64'(6));
        if (tx_log_cyc.size() > idx0)
            checkOutput("first_tx_latency", 64'(tx_log_cyc[idx0] - req_cyc), 64'(2));
        checkOutput("poll_frame", 64'({heart_rate, resolved_angle, speed, adc}),
                    64'({8'd72, 10'h25A, 8'd30, 12'hC34}));

        // Heart cfg
        pushCfg(5, 8'd180, 0);
        applyStimulus(1'b0, 1'b1, 8'd180, 1'b0, 8'd0);
        waitIdle(400);
        checkOutput("heart_err", 64'({err_timeout, err_nack}), 64'(0));

        // Silent responder on byte 3 -> abort with timeout
        silent_code = 3;
        r_hr = 8'd11; r_ang = 10'h3FF; r_spd = 8'd99; r_adc = 12'h123;
        idx0 = tx_log_cyc.size();
        exp_tx.push_back(1); exp_tx.push_back(2);
        for (int i = 0; i <= MR; i++) exp_tx.push_back(3);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        waitIdle(2000);
        silent_code = -1;
        checkOutput("abort_tx_count", 64'(tx_log_cyc.size() - idx0), 64'(3 + MR));
        for (int i = 3; i < 3 + MR; i++) begin
            if (tx_log_cyc.size() > idx0 + i) begin
                gap = tx_log_cyc[idx0 + i] - tx_log_cyc[idx0 + i - 1];
                checkOutput("retry_gap_100_to_102", 64'(gap >= TO && gap <= TO + 2), 64'(1));
            end
        end
        checkOutput("abort_err", 64'({err_timeout, err_nack}), 64'(2'b10));
        checkOutput("abort_keeps_frame", 64'({heart_rate, resolved_angle, speed, adc}),
                    64'({8'd72, 10'h25A, 8'd30, 12'hC34}));

        // Wheel cfg with one NACK on byte 6
        pushCfg(6, 8'd26, 1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 8'd26);
        waitIdle(600);
        checkOutput("wheel_err", 64'({err_timeout, err_nack}), 64'(0));

        // Simultaneous poll + heart cfg while the uart is busy
        v = 8'($urandom);
        r_hr = 8'($urandom); r_ang = 10'($urandom); r_spd = 8'($urandom); r_adc = 12'($urandom);
        idx0 = tx_log_cyc.size();
        pushCfg(5, v, 0);
        pushPoll();
        is_transmitting = 1'b1;
        applyStimulus(1'b1, 1'b1, v, 1'b0, 8'd0);
        repeat (19) @(posedge clk);
        #1 is_transmitting = 1'b0;
        n = cyc;
        waitIdle(800);
        if (tx_log_cyc.size() > idx0)
            checkOutput("tx_after_uart_free", 64'(tx_log_cyc[idx0]), 64'(n));
        checkOutput("prio_tx_count", 64'(tx_log_cyc.size() - idx0), 64'(8));

        // Randomized mix
        for (int i = 0; i < 8; i++) begin
            kind = $urandom_range(0, 2);
            v = 8'($urandom);
            nk = $urandom_range(0, 1);
            if (kind == 0) begin
                r_hr = 8'($urandom); r_ang = 10'($urandom); r_spd = 8'($urandom); r_adc = 12'($urandom);
                pushPoll();
                applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
            end else if (kind == 1) begin
                pushCfg(5, v, nk);
                applyStimulus(1'b0, 1'b1, v, 1'b0, 8'd0);
            end else begin
                pushCfg(6, v, nk);
                applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, v);
            end
            waitIdle(800);
            checkOutput("rand_err", 64'({err_timeout, err_nack}), 64'(0));
        end

        // Reset while waiting on poll step 5
        silent_code = 7;
        r_hr = 8'd200; r_ang = 10'h155; r_spd = 8'd1; r_adc = 12'hFFF;
        idx0 = tx_log_cyc.size();
        exp_tx.push_back(1); exp_tx.push_back(2); exp_tx.push_back(3);
        exp_tx.push_back(4); exp_tx.push_back(7);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        n = 0;
        while (tx_log_cyc.size() < idx0 + 5 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) failNow("reach_step5", tx_log_cyc.size() - idx0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_outputs", 64'({heart_rate, resolved_angle, speed, adc}), 64'(0));
        checkOutput("rst_flags", 64'({busy, transmit, frame_valid, cfg_done, err_timeout, err_nack}), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        silent_code = -1;
        stray_count++;
        repeat (6) @(posedge clk); #1;
        checkOutput("stray_busy", 64'(busy), 64'(0));
        checkOutput("stray_outputs", 64'({heart_rate, resolved_angle, speed, adc}), 64'(0));

        checkOutput("exp_tx_drained", 64'(exp_tx.size()), 64'(0));
        checkOutput("exp_frames_drained", 64'(exp_frames.size()), 64'(0));
        checkOutput("exp_cfg_drained", 64'(exp_cfg.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
